// File: rtl/nios2_vjtag_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG debug host.
// Optional IR caching is selected with the VJTAG_IR_CACHE_EN macro (see top).
package nios2_vjtag_pkg;

  localparam int unsigned IR_W         = 2;
  localparam int unsigned DR_WIDTH_DEF = 38;
  localparam int unsigned TCK_DIV_DEF  = 2;

  localparam logic [IR_W-1:0] IR_OCIMEM    = 2'b00;
  localparam logic [IR_W-1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [IR_W-1:0] IR_BREAK     = 2'b10;
  localparam logic [IR_W-1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/nios2_vjtag_if.sv
// Command/response and vji_* bundle between the debug host and its user.
// master = the host (drives TCK and the virtual-state strobes), slave = the other side.
interface nios2_vjtag_if
  import nios2_vjtag_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEF
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_W-1:0]     cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_data;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [IR_W-1:0]     vji_ir_in;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;
  logic                vji_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, vji_tdo,
    output cmd_ready, rsp_valid, rsp_data,
    output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, vji_tdo,
    input  cmd_ready, rsp_valid, rsp_data,
    input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

endinterface

// File: rtl/nios2_vjtag_tck_gen.sv
// TCK generator: TCK_DIV clk low, TCK_DIV clk high; held low and counter cleared while disabled.
// rise_c/fall_c flag the clk cycle whose closing edge makes TCK rise/fall.
module nios2_vjtag_tck_gen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tck_q, tck_d;
  logic             phase_end_c;

  always_comb begin
    cnt_d       = cnt_q;
    tck_d       = tck_q;
    rise_c      = 1'b0;
    fall_c      = 1'b0;
    phase_end_c = (cnt_q == CNT_W'(TCK_DIV - 1));
    if (!en) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (phase_end_c) begin
      cnt_d  = '0;
      tck_d  = ~tck_q;
      rise_c = ~tck_q;
      fall_c = tck_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck = tck_q;

endmodule

// File: rtl/nios2_vjtag_debug_host.sv
// Host-side virtual-JTAG initiator: one command = UIR, CDR, SDR (DR_WIDTH bits), UDR, then a response pulse.
// Define VJTAG_IR_CACHE_EN to skip UIR when the IR matches the one already loaded.
module nios2_vjtag_debug_host
  import nios2_vjtag_pkg::*;
#(
  parameter int unsigned TCK_DIV  = TCK_DIV_DEF,
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  nios2_vjtag_if.master  bus
);

  localparam int unsigned BIT_W = $clog2(DR_WIDTH);

  state_e              state_q, state_d;
  logic                start_q, start_d;
  logic [IR_W-1:0]     ir_q, ir_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                tdi_q, tdi_d;
  logic [IR_W-1:0]     ir_in_q, ir_in_d;
  logic                uir_q, uir_d;
  logic                cdr_q, cdr_d;
  logic                sdr_q, sdr_d;
  logic                udr_q, udr_d;
  logic                rti_q, rti_d;

  logic tck_en_c, tck_rise_c, tck_fall_c, skip_uir_c;

  assign tck_en_c = (state_q == ST_UIR) || (state_q == ST_CDR) ||
                    (state_q == ST_SDR) || (state_q == ST_UDR);

  nios2_vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (tck_en_c),
    .tck    (bus.vji_tck),
    .rise_c (tck_rise_c),
    .fall_c (tck_fall_c)
  );

`ifdef VJTAG_IR_CACHE_EN
  // ir_in_q doubles as the cached IR; the flag says it has really been loaded since reset.
  logic cached_q, cached_d;

  always_comb begin
    cached_d   = cached_q | (start_q && (state_q == ST_IDLE));
    skip_uir_c = cached_q && (ir_q == ir_in_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cached_q <= 1'b0;
    else       cached_q <= cached_d;
  end
`else
  always_comb skip_uir_c = 1'b0;
`endif

  // Sequencer; every state except IDLE/DONE advances on the TCK fall.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    ir_d       = ir_q;
    shift_d    = shift_q;
    cap_d      = cap_q;
    bit_d      = bit_q;
    rsp_data_d = rsp_data_q;
    ir_in_d    = ir_in_q;

    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          start_d = 1'b0;
          ir_in_d = ir_q;
          state_d = skip_uir_c ? ST_CDR : ST_UIR;
        end else if (bus.cmd_valid && cmd_ready_q) begin
          start_d = 1'b1;
          ir_d    = bus.cmd_ir;
          shift_d = bus.cmd_data;
        end
      end
      ST_UIR: if (tck_fall_c) state_d = ST_CDR;
      ST_CDR: begin
        if (tck_fall_c) begin
          state_d = ST_SDR;
          bit_d   = '0;
        end
      end
      ST_SDR: begin
        if (tck_rise_c) cap_d = {bus.vji_tdo, cap_q[DR_WIDTH-1:1]};
        if (tck_fall_c) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DR_WIDTH - 1)) state_d = ST_UDR;
          else                               bit_d   = bit_q + BIT_W'(1);
        end
      end
      ST_UDR: begin
        if (tck_fall_c) begin
          state_d    = ST_DONE;
          rsp_data_d = cap_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE) && !start_d;
    rti_d       = cmd_ready_d;
    rsp_valid_d = (state_d == ST_DONE);
    uir_d       = (state_d == ST_UIR);
    cdr_d       = (state_d == ST_CDR);
    sdr_d       = (state_d == ST_SDR);
    udr_d       = (state_d == ST_UDR);
    tdi_d       = (state_d == ST_SDR) ? shift_d[0] : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      ir_q        <= '0;
      shift_q     <= '0;
      cap_q       <= '0;
      bit_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      tdi_q       <= 1'b0;
      ir_in_q     <= '0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      ir_q        <= ir_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      bit_q       <= bit_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      tdi_q       <= tdi_d;
      ir_in_q     <= ir_in_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
      rti_q       <= rti_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.vji_tdi   = tdi_q;
  assign bus.vji_ir_in = ir_in_q;
  assign bus.vji_uir   = uir_q;
  assign bus.vji_cdr   = cdr_q;
  assign bus.vji_sdr   = sdr_q;
  assign bus.vji_udr   = udr_q;
  assign bus.vji_rti   = rti_q;

endmodule
